// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_pkg
// Description : Shared types and constants for blocks that consume the
//               edge-triggered flip-flop outputs (debouncer state encoding,
//               glitch statistics sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package dff_pkg;

    // Debouncer FSM states: two stable levels, each with a qualifying state
    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } dff_db_state_t;

    localparam int                      GLITCH_CNT_W   = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'd255;

endpackage : dff_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : 1-bit multi-flop synchronizer with configurable depth and
//               reset value. Brings an asynchronous level into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_stages;

    // Shift the asynchronous input through DEPTH flops; stage 0 may go metastable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stages <= {DEPTH{RST_VAL}};
        end else begin
            r_stages <= {r_stages[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_stages[DEPTH-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/dff_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : dff_debounce_edge
// Description : Synchronizes the flip-flop q level, rejects pulses shorter
//               than STABLE_CYCLES enabled samples, and publishes a debounced
//               level, one-cycle rise/fall strobes, a busy flag and a
//               saturating count of rejected glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_debounce_edge
    import dff_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_in,
    input  logic                    en,
    input  logic                    clr_stats,
    output logic                    level_out,
    output logic                    rise,
    output logic                    fall,
    output logic                    busy,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    // Counter only ever needs to reach STABLE_CYCLES-1
    localparam int                c_cnt_w    = $clog2(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);

    logic                    w_s;
    logic                    w_glitch;

    dff_db_state_t           r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_level;
    logic                    r_rise;
    logic                    r_fall;
    logic                    r_busy;
    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

    sync_chain #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (INIT_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (d_in),
        .o_q (w_s)
    );

    // A candidate is rejected when the sample reverts before qualification ends
    assign w_glitch = en && (((r_state == ST_CHK_HIGH) && !w_s) ||
                             ((r_state == ST_CHK_LOW)  &&  w_s));

    // Debounce FSM with qualification counter and registered level/strobes/busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT_LEVEL ? ST_HIGH : ST_LOW;
            r_cnt   <= '0;
            r_level <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (en) begin
                case (r_state)
                    ST_LOW: begin
                        if (w_s) begin
                            r_state <= ST_CHK_HIGH;
                            r_cnt   <= c_cnt_one;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_CHK_HIGH: begin
                        if (!w_s) begin
                            r_state <= ST_LOW;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == c_cnt_last) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!w_s) begin
                            r_state <= ST_CHK_LOW;
                            r_cnt   <= c_cnt_one;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_CHK_LOW: begin
                        if (w_s) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == c_cnt_last) begin
                            r_state <= ST_LOW;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating glitch statistics; an explicit clear overrides a same-cycle rejection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= '0;
        end else if (clr_stats) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != GLITCH_CNT_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
        end
    end

    assign level_out  = r_level;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign busy       = r_busy;
    assign glitch_cnt = r_glitch_cnt;

endmodule : dff_debounce_edge
`default_nettype wire

// File: tb/tb_dff_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_debounce_edge
// Description : Directed self-checking bench for dff_debounce_edge
//               (SYNC_STAGES=2, STABLE_CYCLES=4; INIT_LEVEL 0 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_debounce_edge;
    import dff_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr_stats;
    logic       d_in;
    logic       d_in_hi;

    logic       level_out, rise, fall, busy;
    logic [7:0] glitch_cnt;
    logic       level_out_hi, rise_hi, fall_hi, busy_hi;
    logic [7:0] glitch_cnt_hi;

    int vectors;
    int miscompares;

    dff_debounce_edge #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .en         (en),
        .clr_stats  (clr_stats),
        .level_out  (level_out),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    dff_debounce_edge #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .INIT_LEVEL    (1'b1)
    ) dut_hi (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in_hi),
        .en         (en),
        .clr_stats  (clr_stats),
        .level_out  (level_out_hi),
        .rise       (rise_hi),
        .fall       (fall_hi),
        .busy       (busy_hi),
        .glitch_cnt (glitch_cnt_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // d_in high for n cycles then low for 4; rise count accumulated in rises
    task automatic pulse(input int n, inout int rises);
        d_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rise) rises++;
        end
        d_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rise) rises++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi_strobes;
        int rises;
        int nen;
        int exp_glitch;

        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        en        = 1'b1;
        clr_stats = 1'b0;
        d_in      = 1'b0;
        d_in_hi   = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_level",   level_out,  0);
        check("rst_rise",    rise,       0);
        check("rst_fall",    fall,       0);
        check("rst_busy",    busy,       0);
        check("rst_glitch",  glitch_cnt, 0);
        check("rst_hi_level", level_out_hi, 1);
        check("rst_hi_busy",  busy_hi,      0);

        // INIT_LEVEL=1 with d_in=1: quiet for 20 cycles
        rst = 1'b0;
        hi_strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rise_hi || fall_hi) hi_strobes++;
        end
        check("hi_no_strobe", hi_strobes, 0);
        check("hi_level",     level_out_hi, 1);

        // Rising latency: d_in changes before edge 0
        d_in = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            check($sformatf("lat_busy_e%0d", k),  busy,      (k >= 2 && k <= 4) ? 1 : 0);
            check($sformatf("lat_rise_e%0d", k),  rise,      (k == 5) ? 1 : 0);
            check($sformatf("lat_level_e%0d", k), level_out, (k >= 5) ? 1 : 0);
        end

        // Falling transition held long enough: single fall
        d_in = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            check($sformatf("fall_busy_e%0d", k),  busy,      (k >= 2 && k <= 4) ? 1 : 0);
            check($sformatf("fall_fall_e%0d", k),  fall,      (k == 5) ? 1 : 0);
            check($sformatf("fall_level_e%0d", k), level_out, (k >= 5) ? 0 : 1);
        end

        // 3-sample pulse is one glitch short of acceptance
        rises = 0;
        pulse(3, rises);
        check("glitch1_cnt",   glitch_cnt, 1);
        check("glitch1_level", level_out,  0);
        check("glitch1_rise",  rises,      0);

        // Saturation at 255
        exp_glitch = 1;
        for (int i = 1; i < 300; i++) begin
            pulse(3, rises);
            exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
            if (i == 253) check("glitch_254", glitch_cnt, 254);
        end
        check("glitch_sat",      glitch_cnt, 255);
        check("glitch_sat_rise", rises,      0);
        check("glitch_sat_lvl",  level_out,  0);

        // Rejection (at edge 5) coinciding with clr_stats
        d_in = 1'b1;
        repeat (3) tick();
        d_in = 1'b0;
        repeat (2) tick();
        check("clr_pre",  glitch_cnt, 255);
        check("clr_busy", busy,       1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_win",       glitch_cnt, 0);
        check("clr_busy_done", busy,       0);
        tick();

        rises = 0;
        pulse(3, rises);
        check("post_clr_glitch", glitch_cnt, 1);

        // Sparse enable: only every 3rd cycle counts
        d_in = 1'b1;
        en   = 1'b0;
        repeat (4) tick();
        check("sparse_idle_busy",  busy,      0);
        check("sparse_idle_level", level_out, 0);
        nen = 0;
        for (int c = 0; c < 15; c++) begin
            en = (c % 3 == 0) ? 1'b1 : 1'b0;
            tick();
            if (en) nen++;
            check($sformatf("sparse_rise_c%0d", c),  rise,      (en && nen == 4) ? 1 : 0);
            check($sformatf("sparse_level_c%0d", c), level_out, (nen >= 4) ? 1 : 0);
            check($sformatf("sparse_busy_c%0d", c),  busy,      (nen >= 1 && nen < 4) ? 1 : 0);
        end
        en = 1'b1;

        // Reset in the middle of a falling qualification
        d_in = 1'b0;
        repeat (3) tick();
        check("midrst_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",   busy,       0);
        check("midrst_rise",   rise,       0);
        check("midrst_fall",   fall,       0);
        check("midrst_glitch", glitch_cnt, 0);
        check("midrst_level",  level_out,  0);
        check("midrst_state",  32'(dut.r_state), 32'(ST_LOW));
        check("midrst_cnt",    32'(dut.r_cnt),   0);
        hi_strobes = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rise || fall) hi_strobes++;
        end
        check("midrst_quiet",  hi_strobes, 0);
        check("midrst_glitch_after", glitch_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dff_debounce_edge
`default_nettype wire
